// File: rtl/muldiv_sched.sv
// muldiv_sched: EX-stage sequencer for the shared multiplier/divider
// and the HI/LO write-back, including MADD/MSUB accumulate.
module muldiv_sched #(
  parameter int DIV_ZERO_FAST = 1,
  parameter int WDOG_CYCLES   = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        flush_exc_i,
  input  logic [63:0] hilo_i,
  output logic        mul_start_o,
  output logic        mul_signed_o,
  input  logic        mul_ready_i,
  input  logic [63:0] mul_result_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        unit_flush_o,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [63:0] hilo_wdata_o,
  output logic [31:0] gpr_result_o,
  output logic        done_o,
  output logic        wdog_err_o
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;

  localparam bit         DZ_EN    = (DIV_ZERO_FAST != 0);
  localparam bit         WDOG_EN  = (WDOG_CYCLES != 0);
  localparam logic [7:0] WDOG_MAX = 8'(WDOG_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      state;
  logic [3:0]  op_q;
  logic        sgn_q;
  logic        div_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] res_q;
  logic [7:0]  cnt_q;

  logic        dec_legal;
  logic        dec_sgn;
  logic        dec_div;
  logic        idle;
  logic        busy;
  logic        done_st;
  logic        accept;
  logic        dz;
  logic        ready_sel;
  logic [63:0] result_sel;
  logic        wdog_hit;
  logic        abort_wd;
  logic        run;
  logic        commit;
  logic [63:0] acc;

  always_comb begin
    dec_legal = 1'b0;
    dec_sgn   = 1'b0;
    dec_div   = 1'b0;
    unique case (1'b1)
      (op_i == OP_MULT) || (op_i == OP_MUL) ||
      (op_i == OP_MADD) || (op_i == OP_MSUB): begin
        dec_legal = 1'b1;
        dec_sgn   = 1'b1;
      end
      (op_i == OP_DIV): begin
        dec_legal = 1'b1;
        dec_sgn   = 1'b1;
        dec_div   = 1'b1;
      end
      (op_i == OP_DIVU): begin
        dec_legal = 1'b1;
        dec_div   = 1'b1;
      end
      (op_i == OP_MULTU) || (op_i == OP_MADDU) ||
      (op_i == OP_MSUBU): begin
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign idle    = (state == S_IDLE);
  assign busy    = (state == S_BUSY);
  assign done_st = (state == S_DONE);

  assign accept = idle & op_valid_i & dec_legal & ~flush_i;
  assign dz     = DZ_EN & dec_div & (src_b_i == 32'd0);

  assign ready_sel  = div_q ? div_ready_i : mul_ready_i;
  assign result_sel = div_q ? div_result_i : mul_result_i;

  // A late result arriving on the last allowed cycle is still accepted.
  assign wdog_hit = WDOG_EN && (cnt_q == WDOG_MAX);
  assign abort_wd = busy & ~flush_i & ~ready_sel & wdog_hit;
  assign run      = busy & ~flush_i & ~abort_wd;

  assign mul_start_o  = run & ~div_q;
  assign div_start_o  = run & div_q;
  assign mul_signed_o = busy & ~div_q & sgn_q;
  assign div_signed_o = busy & div_q & sgn_q;
  assign op_a_o       = a_q;
  assign op_b_o       = b_q;
  assign unit_flush_o = busy & (flush_i | abort_wd);
  assign wdog_err_o   = abort_wd;

  assign stall_o = (idle & op_valid_i & dec_legal) | busy;

  always_comb begin
    acc = res_q;
    unique case (1'b1)
      (op_q == OP_MADD) || (op_q == OP_MADDU):
        acc = hilo_i + res_q;
      (op_q == OP_MSUB) || (op_q == OP_MSUBU):
        acc = hilo_i - res_q;
      default:
        acc = res_q;
    endcase
  end

  assign commit       = done_st & ~stall_i & ~flush_i;
  assign done_o       = commit;
  assign hilo_we_o    = commit & ~flush_exc_i;
  assign hilo_wdata_o = commit ? acc : 64'd0;
  assign gpr_result_o =
    (commit && (op_q == OP_MUL)) ? res_q[31:0] : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      op_q  <= 4'd0;
      sgn_q <= 1'b0;
      div_q <= 1'b0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      res_q <= 64'd0;
      cnt_q <= 8'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= op_i;
            sgn_q <= dec_sgn;
            div_q <= dec_div;
            a_q   <= src_a_i;
            b_q   <= src_b_i;
            cnt_q <= 8'd0;
            if (dz) begin
              res_q <= {src_a_i, 32'hFFFF_FFFF};
              state <= S_DONE;
            end else begin
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + 8'd1;
          if (flush_i) begin
            state <= S_IDLE;
          end else if (ready_sel) begin
            res_q <= result_sel;
            state <= S_DONE;
          end else if (wdog_hit) begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (flush_i || !stall_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: directed vectors and hand sequences
// for the mul/div sequencer, with the bench acting as the units.
module tb_muldiv_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_i;
  logic        flush;
  logic        flush_exc;
  logic [63:0] hilo;
  logic        mul_start_o;
  logic        mul_signed_o;
  logic        mul_ready;
  logic [63:0] mul_result;
  logic        div_start_o;
  logic        div_signed_o;
  logic        div_ready;
  logic [63:0] div_result;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic        unit_flush_o;
  logic        stall_o;
  logic        hilo_we_o;
  logic [63:0] hilo_wdata_o;
  logic [31:0] gpr_result_o;
  logic        done_o;
  logic        wdog_err_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_sched #(
    .DIV_ZERO_FAST(1),
    .WDOG_CYCLES  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid_i  (op_valid),
    .op_i        (op),
    .src_a_i     (a),
    .src_b_i     (b),
    .stall_i     (stall_i),
    .flush_i     (flush),
    .flush_exc_i (flush_exc),
    .hilo_i      (hilo),
    .mul_start_o (mul_start_o),
    .mul_signed_o(mul_signed_o),
    .mul_ready_i (mul_ready),
    .mul_result_i(mul_result),
    .div_start_o (div_start_o),
    .div_signed_o(div_signed_o),
    .div_ready_i (div_ready),
    .div_result_i(div_result),
    .op_a_o      (op_a_o),
    .op_b_o      (op_b_o),
    .unit_flush_o(unit_flush_o),
    .stall_o     (stall_o),
    .hilo_we_o   (hilo_we_o),
    .hilo_wdata_o(hilo_wdata_o),
    .gpr_result_o(gpr_result_o),
    .done_o      (done_o),
    .wdog_err_o  (wdog_err_o)
  );

  // lat = BUSY cycle in which the unit raises ready; 0 = no unit used
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    logic [63:0] res;
    int          lat;
    logic        sgn;
    logic [63:0] exp_wd;
    logic [31:0] exp_gpr;
  } vec_t;

  vec_t vecs[10];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string pre);
    chk({pre, " ctl"},
        {57'd0, mul_start_o, mul_signed_o, div_start_o,
         div_signed_o, unit_flush_o, stall_o, hilo_we_o},
        64'd0);
    chk({pre, " pulse"}, {62'd0, done_o, wdog_err_o}, 64'd0);
    chk({pre, " op_ab"}, {op_a_o, op_b_o}, 64'd0);
    chk({pre, " wdata"}, hilo_wdata_o, 64'd0);
    chk({pre, " gpr"}, {32'd0, gpr_result_o}, 64'd0);
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    logic        isd;
    int          stalls;
    int          writes;
    int          mst;
    int          dst;
    logic        sgn;
    logic [63:0] wd;
    logic [31:0] gr;
    bit          fin;
    v      = vecs[i];
    isd    = (v.op == 4'd2) || (v.op == 4'd3);
    stalls = 0;
    writes = 0;
    mst    = 0;
    dst    = 0;
    sgn    = 1'b0;
    wd     = '0;
    gr     = '0;
    fin    = 1'b0;
    op_valid = 1'b1;
    op   = v.op;
    a    = v.a;
    b    = v.b;
    hilo = v.hilo;
    for (int cyc = 0; cyc < 30 && !fin; cyc++) begin
      mul_ready  = !isd && v.lat > 0 && cyc == v.lat;
      div_ready  = isd && v.lat > 0 && cyc == v.lat;
      mul_result = v.res;
      div_result = v.res;
      @(negedge clk);
      if (stall_o) stalls++;
      if (mul_start_o) mst++;
      if (div_start_o) dst++;
      if ((mul_start_o & mul_signed_o) | (div_start_o & div_signed_o))
        sgn = 1'b1;
      if (hilo_we_o) begin
        writes++;
        wd = hilo_wdata_o;
      end
      if (done_o) begin
        fin = 1'b1;
        gr  = gpr_result_o;
      end
      tick();
      op_valid  = 1'b0;
      mul_ready = 1'b0;
      div_ready = 1'b0;
    end
    chk($sformatf("v%0d done", i), {63'd0, fin}, 64'd1);
    chk($sformatf("v%0d wdata", i), wd, v.exp_wd);
    chk($sformatf("v%0d writes", i), 64'(writes), 64'd1);
    chk($sformatf("v%0d stalls", i), 64'(stalls), 64'(1 + v.lat));
    chk($sformatf("v%0d gpr", i), {32'd0, gr}, {32'd0, v.exp_gpr});
    chk($sformatf("v%0d mul_starts", i), 64'(mst),
        isd ? 64'd0 : 64'(v.lat));
    chk($sformatf("v%0d div_starts", i), 64'(dst),
        isd ? 64'(v.lat) : 64'd0);
    chk($sformatf("v%0d signed", i), {63'd0, sgn}, {63'd0, v.sgn});
    chk($sformatf("v%0d op_ab", i), {op_a_o, op_b_o}, {v.a, v.b});
  endtask

  initial begin
    int first;
    int pulses;

    vecs[0] = '{4'd0, 32'hFFFF_FFFD, 32'd5, 64'd0,
                64'hFFFF_FFFF_FFFF_FFF1, 4, 1'b1,
                64'hFFFF_FFFF_FFFF_FFF1, 32'd0};
    vecs[1] = '{4'd3, 32'd7, 32'd0, 64'd0,
                64'd0, 0, 1'b0,
                {32'd7, 32'hFFFF_FFFF}, 32'd0};
    vecs[2] = '{4'd4, 32'd6, 32'd7, 64'd0,
                64'd42, 2, 1'b1,
                64'd42, 32'd42};
    vecs[3] = '{4'd2, 32'd100, 32'd7, 64'd0,
                64'h0000_0002_0000_000E, 3, 1'b1,
                64'h0000_0002_0000_000E, 32'd0};
    vecs[4] = '{4'd6, 32'd1, 32'd1, 64'h0000_0001_FFFF_FFFF,
                64'd1, 1, 1'b0,
                64'h0000_0002_0000_0000, 32'd0};
    vecs[5] = '{4'd7, 32'd5, 32'd6, 64'd100,
                64'd30, 2, 1'b1,
                64'd70, 32'd0};
    vecs[6] = '{4'd8, 32'd1, 32'd1, 64'd0,
                64'd1, 1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 32'd0};
    vecs[7] = '{4'd5, 32'd1, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF,
                64'd2, 3, 1'b1,
                64'd1, 32'd0};
    vecs[8] = '{4'd2, 32'hFFFF_FFF8, 32'd0, 64'd0,
                64'd0, 0, 1'b0,
                {32'hFFFF_FFF8, 32'hFFFF_FFFF}, 32'd0};
    vecs[9] = '{4'd1, 32'hFFFF_FFFF, 32'd2, 64'd0,
                64'h0000_0001_FFFF_FFFE, 1, 1'b0,
                64'h0000_0001_FFFF_FFFE, 32'd0};

    rst        = 1'b0;
    op_valid   = 1'b0;
    op         = 4'd0;
    a          = '0;
    b          = '0;
    stall_i    = 1'b0;
    flush      = 1'b0;
    flush_exc  = 1'b0;
    hilo       = '0;
    mul_ready  = 1'b0;
    mul_result = '0;
    div_ready  = 1'b0;
    div_result = '0;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    tick();
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // MSUB held in DONE by stall_i; hilo_i taken on release
    op_valid = 1'b1; op = 4'd7; a = 32'd10; b = 32'd3;
    hilo = 64'd5; stall_i = 1'b1;
    @(negedge clk);
    tick();
    op_valid = 1'b0; mul_ready = 1'b1; mul_result = 64'd30;
    @(negedge clk);
    chk("msub busy start", {63'd0, mul_start_o}, 64'd1);
    tick();
    mul_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("msub held%0d", k),
          {61'd0, hilo_we_o, done_o, stall_o}, 64'd0);
      tick();
    end
    stall_i = 1'b0; hilo = 64'd100;
    @(negedge clk);
    chk("msub release we", {62'd0, hilo_we_o, done_o}, 64'd3);
    chk("msub release wdata", hilo_wdata_o, 64'd70);
    tick();
    @(negedge clk);
    chk("msub after", {62'd0, hilo_we_o, done_o}, 64'd0);
    tick();

    // DIV flushed in the same cycle the divider reports ready
    op_valid = 1'b1; op = 4'd2; a = 32'd9; b = 32'd3; hilo = '0;
    @(negedge clk);
    tick();
    op_valid = 1'b0;
    @(negedge clk);
    chk("div start", {62'd0, div_start_o, div_signed_o}, 64'd3);
    tick();
    div_ready = 1'b1; div_result = 64'd3; flush = 1'b1;
    @(negedge clk);
    chk("div flush uf", {63'd0, unit_flush_o}, 64'd1);
    chk("div flush start", {63'd0, div_start_o}, 64'd0);
    chk("div flush we", {62'd0, hilo_we_o, done_o}, 64'd0);
    tick();
    div_ready = 1'b0; flush = 1'b0;
    op_valid = 1'b1; op = 4'd0; a = 32'd2; b = 32'd2;
    @(negedge clk);
    chk("post flush idle", {61'd0, stall_o, div_start_o, hilo_we_o},
        64'd4);
    tick();
    op_valid = 1'b0;
    @(negedge clk);
    chk("post flush new op", {63'd0, mul_start_o}, 64'd1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("mul flush uf", {63'd0, unit_flush_o}, 64'd1);
    tick();
    flush = 1'b0;

    // MADDU commit suppressed by a MEM exception
    op_valid = 1'b1; op = 4'd6; a = 32'd1; b = 32'd5; hilo = 64'd10;
    @(negedge clk);
    tick();
    op_valid = 1'b0; mul_ready = 1'b1; mul_result = 64'd5;
    @(negedge clk);
    tick();
    mul_ready = 1'b0; flush_exc = 1'b1;
    @(negedge clk);
    chk("exc commit", {62'd0, done_o, hilo_we_o}, 64'd2);
    tick();
    flush_exc = 1'b0;
    @(negedge clk);
    chk("exc after", {62'd0, done_o, hilo_we_o}, 64'd0);
    tick();

    // MUL flushed while waiting in DONE
    op_valid = 1'b1; op = 4'd4; a = 32'd3; b = 32'd3;
    @(negedge clk);
    tick();
    op_valid = 1'b0; mul_ready = 1'b1; mul_result = 64'd9;
    @(negedge clk);
    tick();
    mul_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("done flush", {62'd0, done_o, hilo_we_o}, 64'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("done flush after", {62'd0, done_o, hilo_we_o}, 64'd0);
    tick();

    // illegal opcode is ignored
    op_valid = 1'b1; op = 4'd9;
    @(negedge clk);
    chk("illegal stall", {63'd0, stall_o}, 64'd0);
    tick();
    op_valid = 1'b0;
    @(negedge clk);
    chk("illegal idle", {61'd0, mul_start_o, div_start_o, stall_o},
        64'd0);
    tick();

    // watchdog: multiplier never answers
    op_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
    @(negedge clk);
    tick();
    op_valid = 1'b0;
    first  = 0;
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (wdog_err_o) begin
        pulses++;
        if (first == 0) first = c;
        chk("wdog uf", {63'd0, unit_flush_o}, 64'd1);
      end
      tick();
    end
    chk("wdog pulses", 64'(pulses), 64'd1);
    chk("wdog cycle", 64'(first), 64'd9);
    @(negedge clk);
    chk("wdog idle", {63'd0, stall_o}, 64'd0);
    tick();

    // reset while BUSY
    op_valid = 1'b1; op = 4'd0; a = 32'h1234; b = 32'd5;
    @(negedge clk);
    tick();
    op_valid = 1'b0;
    @(negedge clk);
    chk("pre-rst busy", {63'd0, mul_start_o}, 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk_zero("mid rst");
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("after rst", {61'd0, stall_o, mul_start_o, hilo_we_o}, 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
